// File: rtl/temp_frame_rx.sv
// temp_frame_rx: single-wire sensor frame deserializer.
// Line format: start(0), temp[7:0] MSB first, flip, [parity], stop(1).
// Each bit lasts BIT_CYCLES clocks. The start bit is sampled mid-bit, and
// every later bit is sampled one full bit period after the previous sample.
// Good frames update temp/flip with a one-cycle valid pulse. Bad frames
// give a one-cycle frame_err pulse and leave temp/flip untouched.
// Optional feature: define TEMP_FRAME_RX_PARITY_EN to add an even-parity
// bit after flip (XOR of temp, flip and parity must be 0).
module temp_frame_rx #(
  parameter int BIT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sdi,
  output logic [7:0] temp,
  output logic       flip,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int HALF = BIT_CYCLES >> 1;
  localparam int CW   = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);

`ifdef TEMP_FRAME_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, FLIP, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, FLIP, STOP} state_t;
`endif

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [7:0]      shreg;
  logic            flip_cap;
  logic            half_done;
  logic            bit_done;
  logic            frame_ok;

`ifdef TEMP_FRAME_RX_PARITY_EN
  logic            par_acc;
  logic            par_bad;
  assign frame_ok = sdi & ~par_bad;
`else
  assign frame_ok = sdi;
`endif

  assign half_done = (cnt == CNT_HALF);
  assign bit_done  = (cnt == CNT_LAST);
  assign busy      = (state != IDLE);

  // Receive FSM: bit timing, deserialization, frame check and output update
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      temp      <= 8'h00;
      flip      <= 1'b0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef TEMP_FRAME_RX_PARITY_EN
      par_acc   <= 1'b0;
      par_bad   <= 1'b0;
`endif
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!sdi) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (half_done) begin
            cnt   <= '0;
            idx   <= '0;
`ifdef TEMP_FRAME_RX_PARITY_EN
            par_acc <= 1'b0;
            par_bad <= 1'b0;
`endif
            // A line that is high again mid-start-bit was only a glitch
            state <= sdi ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            cnt   <= '0;
            shreg <= {shreg[6:0], sdi};
            idx   <= idx + 3'd1;
`ifdef TEMP_FRAME_RX_PARITY_EN
            par_acc <= par_acc ^ sdi;
`endif
            if (idx == 3'd7) state <= FLIP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FLIP: begin
          if (bit_done) begin
            cnt      <= '0;
            flip_cap <= sdi;
`ifdef TEMP_FRAME_RX_PARITY_EN
            par_acc  <= par_acc ^ sdi;
            state    <= PARITY;
`else
            state    <= STOP;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef TEMP_FRAME_RX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            cnt     <= '0;
            par_bad <= par_acc ^ sdi;
            state   <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          if (bit_done) begin
            cnt   <= '0;
            state <= IDLE;
            if (frame_ok) begin
              temp  <= shreg;
              flip  <= flip_cap;
              valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
